// File: rtl/alu_pkg.sv
// Shared ALU arithmetic definitions: default datapath width and the
// shift-add multiplier state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : alu_pkg

// File: rtl/parallel_adder.sv
// Combinational WIDTH-bit ripple-free adder: {Cout, G} = A + Y + Cin.
module parallel_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] G,
  output logic             Cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, A} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
  end

  assign G    = sum[WIDTH-1:0];
  assign Cout = sum[WIDTH];

endmodule : parallel_adder

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle unsigned WIDTHxWIDTH shift-add multiplier with valid/ready
// operand and result handshakes; one adder step per clock.
module shift_add_mul_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nonzero,
  output logic               busy
);

  mul_state_e state_q, state_d;

  logic [WIDTH-1:0] m_q,    m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_g;
  logic             add_cout;
  logic             last_step;

  assign add_y     = p_lo_q[0] ? m_q : '0;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  parallel_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A    (p_hi_q),
    .Y    (add_y),
    .Cin  (1'b0),
    .G    (add_g),
    .Cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_step)   state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      IDLE: start_ready = 1'b1;
      RUN:  busy        = 1'b1;
      DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Adder carry-out becomes the top bit shifted into P_hi, keeping the
  // full 2W-bit product exact.
  always_comb begin
    m_d    = m_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          m_d    = a_in;
          p_hi_d = '0;
          p_lo_d = b_in;
          cnt_d  = '0;
        end
      end
      RUN: begin
        {p_hi_d, p_lo_d} = {add_cout, add_g, p_lo_q[WIDTH-1:1]};
        cnt_d            = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q    <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      cnt_q  <= '0;
    end else begin
      m_q    <= m_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign product    = {p_hi_q, p_lo_q};
  assign hi_nonzero = |p_hi_q;

endmodule : shift_add_mul_ctrl

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed self-checking bench for shift_add_mul_ctrl: vector table of
// products plus hand-written handshake, backpressure and reset sequences.
module tb_shift_add_mul_ctrl;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] product;
  logic           hi_nonzero;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_mul_ctrl #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .hi_nonzero  (hi_nonzero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    logic           hnz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    while (!start_ready && waited < 10) begin
      step();
      waited++;
    end
    check("accept_ready", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    a_in        = a;
    b_in        = b;
    step();
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    logic [2*W-1:0] held;
    accept(v.a, v.b);
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_ready_run"}, 64'(start_ready), 64'd0);
    wait_result(lat);
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_product"}, product, v.prod);
    check({tag, "_hi_nonzero"}, 64'(hi_nonzero), 64'(v.hnz));
    check({tag, "_ready_done"}, 64'(start_ready), 64'd0);
    held      = product;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_hold"}, product, held);
  endtask

  initial begin
    int lat;
    int seen;
    logic [2*W-1:0] held;

    vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, prod: 64'hFFFF_FFFE_0000_0001, hnz: 1'b1};
    vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0002, prod: 64'h0000_0000_FFFF_FFFE, hnz: 1'b0};
    vecs[2] = '{a: 32'h0000_0000, b: 32'h1234_5678, prod: 64'h0,                   hnz: 1'b0};
    vecs[3] = '{a: 32'h0000_0003, b: 32'h0000_0005, prod: 64'd15,                  hnz: 1'b0};
    vecs[4] = '{a: 32'h0001_0000, b: 32'h0001_0000, prod: 64'h0000_0001_0000_0000, hnz: 1'b1};
    vecs[5] = '{a: 32'h1234_5678, b: 32'h0000_0001, prod: 64'h0000_0000_1234_5678, hnz: 1'b0};
    vecs[6] = '{a: 32'h8000_0000, b: 32'h0000_0003, prod: 64'h0000_0001_8000_0000, hnz: 1'b1};

    rst_n       = 1'b0;
    start_valid = 1'b1;
    res_ready   = 1'b1;
    a_in        = 32'hDEAD_BEEF;
    b_in        = 32'h0000_0007;
    step();
    step();
    check("rst_ready", 64'(start_ready), 64'd1);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'h0);
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a_in        = '0;
    b_in        = '0;
    rst_n       = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result must hold for as long as res_ready stays low.
    accept(32'h0000_1234, 32'h0000_0010);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'd32);
    held = product;
    check("bp_product", held, 64'h0000_0000_0001_2340);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_product", product, held);
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_ready", 64'(start_ready), 64'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_release_idle", 64'(start_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);

    // New request during RUN must be ignored.
    accept(32'd6, 32'd7);
    for (int i = 0; i < 5; i++) step();
    start_valid = 1'b1;
    a_in        = 32'd100;
    b_in        = 32'd100;
    for (int i = 0; i < 4; i++) step();
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
    wait_result(lat);
    check("midrun_latency", 64'(lat + 9), 64'd32);
    check("midrun_product", product, 64'd42);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("midrun_back_idle", 64'(start_ready), 64'd1);

    // Reset at count=10 aborts; no result may ever appear.
    accept(32'hFFFF_FFFF, 32'h0000_00FF);
    for (int i = 0; i < 10; i++) step();
    rst_n     = 1'b0;
    res_ready = 1'b1;
    step();
    rst_n     = 1'b1;
    res_ready = 1'b0;
    check("abort_ready", 64'(start_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (res_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_vec("post_abort", vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_add_mul_ctrl
